// File: rtl/ic_code_entry_if.sv
// Key-entry bus between the front-panel keypad decoder and the code-entry block.
// master = keypad / test sequencer side, slave = ic_code_entry.
interface ic_code_entry_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic [7:0]              iKEY_CODE;
  logic                    iKEY_VALID;
  logic [7*NUM_DIGITS-1:0] oHEX;
  logic [4*NUM_DIGITS-1:0] oCODE;
  logic [CW-1:0]           oCOUNT;
  logic                    ic_read;
  logic                    oCOMMIT;
  logic                    oREJECT;

  modport master (
    output iKEY_CODE, iKEY_VALID,
    input  oHEX, oCODE, oCOUNT, ic_read, oCOMMIT, oREJECT
  );

  modport slave (
    input  iKEY_CODE, iKEY_VALID,
    output oHEX, oCODE, oCOUNT, ic_read, oCOMMIT, oREJECT
  );
endinterface

// File: rtl/ic_code_entry.sv
// Hex digit-entry controller: collects NUM_DIGITS digits from key strobes,
// drives active-low 7-segment displays and presents a committed IC code.
module ic_code_entry #(
  parameter int         NUM_DIGITS  = 4,
  parameter bit         AUTO_COMMIT = 1'b0,
  parameter logic [7:0] CLEAR_CODE  = 8'h17,
  parameter logic [7:0] BKSP_CODE   = 8'h66,
  parameter logic [7:0] ENTER_CODE  = 8'h5A
) (
  input logic            iCLK,
  input logic            iRST,
  ic_code_entry_if.slave bus
);
  localparam int             CW       = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(NUM_DIGITS);
  localparam logic [CW-1:0]  ONE_CNT  = CW'(1);
  localparam logic [1:0]     S_IDLE   = 2'd0;
  localparam logic [1:0]     S_ENTRY  = 2'd1;
  localparam logic [1:0]     S_FULL   = 2'd2;
  localparam logic [1:0]     S_DONE   = 2'd3;
  localparam logic [6:0]     DASH     = 7'b0111111;

  logic [1:0]                 state;
  logic [CW-1:0]              count;
  logic [NUM_DIGITS-1:0][3:0] digs;
  logic                       key_prev;
  logic                       commit;
  logic                       reject;
  logic                       ev;
  logic                       is_digit;
  logic [3:0]                 digit;

  assign ev       = bus.iKEY_VALID & ~key_prev;
  assign is_digit = (bus.iKEY_CODE[7:4] == 4'h0);
  assign digit    = bus.iKEY_CODE[3:0];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0011000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= S_IDLE;
      count    <= '0;
      digs     <= '0;
      key_prev <= 1'b1;   // a strobe held through reset must not count as a new key
      commit   <= 1'b0;
      reject   <= 1'b0;
    end else begin
      key_prev <= bus.iKEY_VALID;
      commit   <= 1'b0;
      reject   <= 1'b0;
      if (ev) begin
        if (is_digit) begin
          if (state == S_DONE) begin
            // new entry replaces the committed code
            digs                 <= '0;
            digs[NUM_DIGITS-1]   <= digit;
            count                <= ONE_CNT;
            if (NUM_DIGITS == 1 && AUTO_COMMIT) begin
              state  <= S_DONE;
              commit <= 1'b1;
            end else begin
              state <= (NUM_DIGITS == 1) ? S_FULL : S_ENTRY;
            end
          end else if (state == S_FULL) begin
            reject <= 1'b1;
          end else begin
            for (int i = 0; i < NUM_DIGITS; i++)
              if (i + int'(count) == NUM_DIGITS - 1) digs[i] <= digit;
            count <= count + 1'b1;
            if (count + 1'b1 == FULL_CNT) begin
              if (AUTO_COMMIT) begin
                state  <= S_DONE;
                commit <= 1'b1;
              end else begin
                state <= S_FULL;
              end
            end else begin
              state <= S_ENTRY;
            end
          end
        end else if (bus.iKEY_CODE == CLEAR_CODE) begin
          state <= S_IDLE;
          count <= '0;
          digs  <= '0;
        end else if (bus.iKEY_CODE == BKSP_CODE) begin
          if (count == '0) begin
            reject <= 1'b1;
          end else begin
            for (int i = 0; i < NUM_DIGITS; i++)
              if (i + int'(count) == NUM_DIGITS) digs[i] <= 4'h0;
            count <= count - 1'b1;
            state <= (count == ONE_CNT) ? S_IDLE : S_ENTRY;
          end
        end else if (bus.iKEY_CODE == ENTER_CODE) begin
          if (state == S_FULL) begin
            state  <= S_DONE;
            commit <= 1'b1;
          end else if (state != S_DONE) begin
            reject <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.oCODE   = digs;
  assign bus.oCOUNT  = count;
  assign bus.ic_read = (state == S_DONE);
  assign bus.oCOMMIT = commit;
  assign bus.oREJECT = reject;

  // display k shows nibble k; it is entered once count reaches NUM_DIGITS-k
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_disp
    assign bus.oHEX[7*k +: 7] = (k + int'(count) >= NUM_DIGITS) ? seg7(digs[k]) : DASH;
  end
endmodule

// File: tb/tb_ic_code_entry.sv
// Directed bench: table-driven vectors on a 4-digit manual-commit build,
// plus hand sequences for held strobe, reset, auto-commit and a 6-digit build.
module tb_ic_code_entry;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ic_code_entry_if #(.NUM_DIGITS(4)) bus_a ();
  ic_code_entry_if #(.NUM_DIGITS(4)) bus_b ();
  ic_code_entry_if #(.NUM_DIGITS(6)) bus_c ();

  ic_code_entry #(.NUM_DIGITS(4), .AUTO_COMMIT(1'b0)) dut_a (.iCLK(clk), .iRST(rst), .bus(bus_a));
  ic_code_entry #(.NUM_DIGITS(4), .AUTO_COMMIT(1'b1)) dut_b (.iCLK(clk), .iRST(rst), .bus(bus_b));
  ic_code_entry #(.NUM_DIGITS(6), .AUTO_COMMIT(1'b0)) dut_c (.iCLK(clk), .iRST(rst), .bus(bus_c));

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  code;
    logic [2:0]  cnt;
    logic [15:0] ecode;
    logic        rd;
    logic        cm;
    logic        rj;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] c,
                              input logic [2:0] n, input logic [15:0] e,
                              input logic rd, input logic cm, input logic rj);
    vec_t t;
    t.rst = r; t.v = v; t.code = c; t.cnt = n; t.ecode = e;
    t.rd = rd; t.cm = cm; t.rj = rj;
    return t;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tbl[d];
  endfunction

  // nibble k is shown on display k once the first (4-k) positions are entered
  function automatic logic [27:0] hex4(input logic [15:0] c, input logic [2:0] n);
    logic [27:0] h;
    for (int k = 0; k < 4; k++)
      h[7*k +: 7] = (k >= 4 - int'(n)) ? seg(c[4*k +: 4]) : 7'b0111111;
    return h;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic press_a(input logic [7:0] c);
    @(negedge clk); bus_a.iKEY_VALID = 1'b1; bus_a.iKEY_CODE = c; @(posedge clk); #1;
  endtask
  task automatic rel_a();
    @(negedge clk); bus_a.iKEY_VALID = 1'b0; @(posedge clk); #1;
  endtask
  task automatic press_b(input logic [7:0] c);
    @(negedge clk); bus_b.iKEY_VALID = 1'b1; bus_b.iKEY_CODE = c; @(posedge clk); #1;
  endtask
  task automatic rel_b();
    @(negedge clk); bus_b.iKEY_VALID = 1'b0; @(posedge clk); #1;
  endtask
  task automatic press_c(input logic [7:0] c);
    @(negedge clk); bus_c.iKEY_VALID = 1'b1; bus_c.iKEY_CODE = c; @(posedge clk); #1;
  endtask
  task automatic rel_c();
    @(negedge clk); bus_c.iKEY_VALID = 1'b0; @(posedge clk); #1;
  endtask
  task automatic do_reset();
    @(negedge clk); rst = 1'b1; @(posedge clk); #1;
    @(negedge clk); rst = 1'b0; @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] seq6 [7];
    bus_a.iKEY_VALID = 1'b0; bus_a.iKEY_CODE = 8'h00;
    bus_b.iKEY_VALID = 1'b0; bus_b.iKEY_CODE = 8'h00;
    bus_c.iKEY_VALID = 1'b0; bus_c.iKEY_CODE = 8'h00;

    // reset, 7408 + ENTER, double ENTER, clear
    tv.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h07, 1, 16'h7000, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 1, 16'h7000, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h04, 2, 16'h7400, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 2, 16'h7400, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h00, 3, 16'h7400, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 3, 16'h7400, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h08, 4, 16'h7408, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 4, 16'h7408, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h5A, 4, 16'h7408, 1, 1, 0));
    tv.push_back(mk(0, 0, 8'h00, 4, 16'h7408, 1, 0, 0));
    tv.push_back(mk(0, 1, 8'h5A, 4, 16'h7408, 1, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 4, 16'h7408, 1, 0, 0));
    tv.push_back(mk(0, 1, 8'h17, 0, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0, 0, 0));
    // 3,2, BKSP x3, ENTER in IDLE
    tv.push_back(mk(0, 1, 8'h03, 1, 16'h3000, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 1, 16'h3000, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h02, 2, 16'h3200, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 2, 16'h3200, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h66, 1, 16'h3000, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 1, 16'h3000, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h66, 0, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h66, 0, 16'h0000, 0, 0, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h5A, 0, 16'h0000, 0, 0, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0, 0, 0));
    // 1234, 5th digit refused, commit, BKSP out of DONE, refill, clear
    tv.push_back(mk(0, 1, 8'h01, 1, 16'h1000, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 1, 16'h1000, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h02, 2, 16'h1200, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 2, 16'h1200, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h03, 3, 16'h1230, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 3, 16'h1230, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h5A, 3, 16'h1230, 0, 0, 1));
    tv.push_back(mk(0, 0, 8'h00, 3, 16'h1230, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h04, 4, 16'h1234, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 4, 16'h1234, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h09, 4, 16'h1234, 0, 0, 1));
    tv.push_back(mk(0, 0, 8'h00, 4, 16'h1234, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h5A, 4, 16'h1234, 1, 1, 0));
    tv.push_back(mk(0, 0, 8'h00, 4, 16'h1234, 1, 0, 0));
    tv.push_back(mk(0, 1, 8'h66, 3, 16'h1230, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 3, 16'h1230, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h05, 4, 16'h1235, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 4, 16'h1235, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h17, 0, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0, 0, 0));
    // unknown code, then code change without a strobe edge
    tv.push_back(mk(0, 1, 8'h20, 0, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h05, 0, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h05, 1, 16'h5000, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 1, 16'h5000, 0, 0, 0));

    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst;
      bus_a.iKEY_VALID = tv[i].v;
      bus_a.iKEY_CODE  = tv[i].code;
      @(posedge clk); #1;
      chk($sformatf("v%0d_count", i), bus_a.oCOUNT, tv[i].cnt);
      chk($sformatf("v%0d_code", i), bus_a.oCODE, tv[i].ecode);
      chk($sformatf("v%0d_read", i), bus_a.ic_read, tv[i].rd);
      chk($sformatf("v%0d_commit", i), bus_a.oCOMMIT, tv[i].cm);
      chk($sformatf("v%0d_reject", i), bus_a.oREJECT, tv[i].rj);
      chk($sformatf("v%0d_hex", i), bus_a.oHEX, hex4(tv[i].ecode, tv[i].cnt));
    end

    // strobe held high for 20 cycles stores exactly one digit
    press_a(8'h17); rel_a();
    @(negedge clk); bus_a.iKEY_VALID = 1'b1; bus_a.iKEY_CODE = 8'h05;
    repeat (20) @(posedge clk);
    #1;
    chk("held_count", bus_a.oCOUNT, 3'd1);
    chk("held_code", bus_a.oCODE, 16'h5000);

    // reset during ENTRY with strobe still high
    @(negedge clk); rst = 1'b1; @(posedge clk); #1;
    chk("rst_count", bus_a.oCOUNT, 3'd0);
    chk("rst_code", bus_a.oCODE, 16'h0000);
    chk("rst_hex", bus_a.oHEX, {4{7'b0111111}});
    chk("rst_flags", {bus_a.ic_read, bus_a.oCOMMIT, bus_a.oREJECT}, 3'b000);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held_no_key", bus_a.oCOUNT, 3'd0);
    rel_a();
    press_a(8'h06);
    chk("rst_rearm_count", bus_a.oCOUNT, 3'd1);
    chk("rst_rearm_code", bus_a.oCODE, 16'h6000);
    rel_a();

    // auto-commit build
    do_reset();
    press_b(8'h07); rel_b();
    press_b(8'h04); rel_b();
    press_b(8'h00); rel_b();
    press_b(8'h08);
    chk("auto_read", bus_b.ic_read, 1'b1);
    chk("auto_commit", bus_b.oCOMMIT, 1'b1);
    chk("auto_count", bus_b.oCOUNT, 3'd4);
    rel_b();
    chk("auto_commit_1cyc", bus_b.oCOMMIT, 1'b0);
    chk("auto_hex", bus_b.oHEX, 28'b1111000_0011001_1000000_0000000);
    press_b(8'h5A);
    chk("auto_enter_nopulse", {bus_b.oCOMMIT, bus_b.oREJECT}, 2'b00);
    chk("auto_enter_read", bus_b.ic_read, 1'b1);
    chk("auto_enter_code", bus_b.oCODE, 16'h7408);
    rel_b();

    // 6-digit build
    seq6 = '{8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h5A};
    for (int i = 0; i < 7; i++) begin
      press_c(seq6[i]); rel_c();
    end
    chk("n6_code", bus_c.oCODE, 24'hABC012);
    chk("n6_read", bus_c.ic_read, 1'b1);
    chk("n6_count", bus_c.oCOUNT, 3'd6);
    press_c(8'h05);
    chk("n6_redo_read", bus_c.ic_read, 1'b0);
    chk("n6_redo_count", bus_c.oCOUNT, 3'd1);
    chk("n6_redo_code", bus_c.oCODE, 24'h500000);
    chk("n6_redo_hex", bus_c.oHEX, {7'b0010010, {5{7'b0111111}}});
    rel_c();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
